mem_stage_lsu: RTL and testbench

Memory-access stage of the 5-stage pipeline. It consumes the EX/MEM instruction, the ALU-computed address, and the store data already resolved by the MEM-stage store-data forwarder. It runs a request/grant/response handshake with data memory, and generates byte enables and load alignment with sign/zero extension. It owns the MEM/WB pipeline register and stalls the upstream pipeline while a memory transaction is outstanding.

---
 rtl/mem_stage_lsu.sv | 162 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM stage: data-memory req/gnt/rsp handshake, byte lanes, load extension, MEM/WB register.
// Build option MEM_MISALIGN_TRAP_EN turns misaligned accesses into a one-cycle trap instead of a truncated access.
module mem_stage_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid,
  input  logic [31:0] instr_ex_mem,
  input  logic [31:0] ex_mem_output,
  input  logic [31:0] store_data_final,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        mem_wb_valid,
  output logic [31:0] instr_mem_wb,
  output logic [31:0] mem_wb_output,
  output logic        misalign_trap
);
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;

  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [31:0] NOP      = 32'h00000013;

  state_t      state_q, state_d;
  logic        mem_wb_valid_q, mem_wb_valid_d;
  logic [31:0] instr_mem_wb_q, instr_mem_wb_d;
  logic [31:0] mem_wb_output_q, mem_wb_output_d;
  logic        misalign_trap_q, misalign_trap_d;

  logic        is_load, is_store, is_mem, zext, misaligned;
  logic [1:0]  size, a_lo;
  logic [2:0]  funct3;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_ext, result;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        req_c, stall_c, complete;
  logic        unused_instr;

  assign funct3       = instr_ex_mem[14:12];
  assign is_load      = instr_ex_mem[6:0] == OP_LOAD;
  assign is_store     = instr_ex_mem[6:0] == OP_STORE;
  assign is_mem       = is_load | is_store;
  assign size         = funct3[1:0];
  assign zext         = funct3[2];
  assign a_lo         = ex_mem_output[1:0];
  assign unused_instr = ^{instr_ex_mem[31:15], instr_ex_mem[11:7]};

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = is_mem && ((size == 2'b01 && a_lo[0]) || (size[1] && a_lo != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Half uses only a[1] and word ignores a[1:0], so misaligned addresses truncate naturally.
  always_comb begin
    be_c     = 4'b1111;
    wdata_c  = store_data_final;
    ld_byte  = dmem_rdata[{a_lo, 3'b000} +: 8];
    ld_half  = a_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_ext = dmem_rdata;
    case (size)
      2'b00: begin
        be_c     = 4'b0001 << a_lo;
        wdata_c  = {4{store_data_final[7:0]}};
        load_ext = {{24{~zext & ld_byte[7]}}, ld_byte};
      end
      2'b01: begin
        be_c     = 4'b0011 << {a_lo[1], 1'b0};
        wdata_c  = {2{store_data_final[15:0]}};
        load_ext = {{16{~zext & ld_half[15]}}, ld_half};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    req_c           = 1'b0;
    stall_c         = 1'b0;
    complete        = 1'b0;
    result          = ex_mem_output;
    misalign_trap_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_mem_valid) begin
          if (!is_mem) begin
            complete = 1'b1;
          end else if (misaligned) begin
            misalign_trap_d = 1'b1;
          end else begin
            req_c = 1'b1;
            if (dmem_gnt && is_store) begin
              complete = 1'b1;
            end else begin
              stall_c = 1'b1;
              state_d = dmem_gnt ? WAIT_RSP : WAIT_GNT;
            end
          end
        end
      end
      WAIT_GNT: begin
        req_c = 1'b1;
        if (dmem_gnt && is_store) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          stall_c = 1'b1;
          if (dmem_gnt) state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (dmem_rvalid) begin
          complete = 1'b1;
          result   = load_ext;
          state_d  = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Anything that does not complete leaves a NOP so downstream never matches a stale rd.
    mem_wb_valid_d  = complete;
    instr_mem_wb_d  = complete ? instr_ex_mem : NOP;
    mem_wb_output_d = complete ? result : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      mem_wb_valid_q  <= 1'b0;
      instr_mem_wb_q  <= NOP;
      mem_wb_output_q <= 32'h0;
      misalign_trap_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      mem_wb_valid_q  <= mem_wb_valid_d;
      instr_mem_wb_q  <= instr_mem_wb_d;
      mem_wb_output_q <= mem_wb_output_d;
      misalign_trap_q <= misalign_trap_d;
    end
  end

  assign dmem_req      = req_c & ~rst;
  assign stall         = stall_c & ~rst;
  assign dmem_we       = dmem_req & is_store;
  assign dmem_addr     = dmem_req ? {ex_mem_output[31:2], 2'b00} : 32'h0;
  assign dmem_be       = dmem_req ? be_c : 4'b0000;
  assign dmem_wdata    = (dmem_req && is_store) ? wdata_c : 32'h0;
  assign mem_wb_valid  = mem_wb_valid_q;
  assign instr_mem_wb  = instr_mem_wb_q;
  assign mem_wb_output = mem_wb_output_q;
  assign misalign_trap = misalign_trap_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: stimulus pushes expected MEM/WB results, a monitor pops and compares.
module tb_mem_stage_lsu;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] I_ADD = 32'h002082B3;
  localparam logic [31:0] I_SB  = 32'h00208023;
  localparam logic [31:0] I_SH  = 32'h00209023;
  localparam logic [31:0] I_LB  = 32'h00008283;
  localparam logic [31:0] I_LBU = 32'h0000C283;
  localparam logic [31:0] I_LH  = 32'h00009283;
  localparam logic [31:0] I_LW  = 32'h0000A283;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_valid;
  logic [31:0] instr_ex_mem, ex_mem_output, store_data_final;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall, mem_wb_valid, misalign_trap;
  logic [31:0] instr_mem_wb, mem_wb_output;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [31:0] out;
    logic        trap;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .ex_mem_valid(ex_mem_valid), .instr_ex_mem(instr_ex_mem),
    .ex_mem_output(ex_mem_output), .store_data_final(store_data_final),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .stall(stall),
    .mem_wb_valid(mem_wb_valid), .instr_mem_wb(instr_mem_wb),
    .mem_wb_output(mem_wb_output), .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] addr, input logic [31:0] sd);
    ex_mem_valid     = v;
    instr_ex_mem     = ins;
    ex_mem_output    = addr;
    store_data_final = sd;
  endtask

  task automatic push(input logic v, input logic [31:0] ins, input logic [31:0] out, input logic trap);
    exp_t e;
    e.v = v; e.instr = ins; e.out = out; e.trap = trap;
    sb.push_back(e);
  endtask

  // Load granted in its first cycle, data returned in the next.
  task automatic do_load(input string name, input logic [31:0] ins, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] res);
    step();
    drive(1'b1, ins, addr, 32'h0);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
    @(negedge clk);
    chk({name, "_stall_c0"}, {31'h0, stall}, 32'h1);
    chk({name, "_req"}, {31'h0, dmem_req}, 32'h1);
    chk({name, "_we"}, {31'h0, dmem_we}, 32'h0);
    chk({name, "_be"}, {28'h0, dmem_be}, {28'h0, be});
    chk({name, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
    push(1'b1, ins, res, 1'b0);
    @(negedge clk);
    chk({name, "_stall_c1"}, {31'h0, stall}, 32'h0);
    chk({name, "_req_c1"}, {31'h0, dmem_req}, 32'h0);
  endtask

  // Scoreboard monitor: every live MEM/WB (or trap) pops one expectation; bubbles must hold NOP.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (mem_wb_valid === 1'b1 || misalign_trap === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wb: got instr 0x%08h out 0x%08h expected no result", instr_mem_wb, mem_wb_output);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wb_valid", {31'h0, mem_wb_valid}, {31'h0, e.v});
          chk("wb_instr", instr_mem_wb, e.instr);
          if (e.v) chk("wb_output", mem_wb_output, e.out);
          chk("wb_trap", {31'h0, misalign_trap}, {31'h0, e.trap});
        end
      end else begin
        chk("bubble_instr", instr_mem_wb, NOP);
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, NOP, 32'h0, 32'h0);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'h0, mem_wb_valid}, 32'h0);
    chk("rst_instr", instr_mem_wb, NOP);
    chk("rst_output", mem_wb_output, 32'h0);
    chk("rst_trap", {31'h0, misalign_trap}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_req", {31'h0, dmem_req}, 32'h0);

    // Non-memory op: one cycle, no request, no stall.
    step();
    drive(1'b1, I_ADD, 32'h1234, 32'h0);
    push(1'b1, I_ADD, 32'h1234, 1'b0);
    @(negedge clk);
    chk("add_stall", {31'h0, stall}, 32'h0);
    chk("add_req", {31'h0, dmem_req}, 32'h0);

    // Store byte to lane 3, granted immediately.
    step();
    drive(1'b1, I_SB, 32'h1003, 32'h000000AB);
    dmem_gnt = 1'b1;
    push(1'b1, I_SB, 32'h1003, 1'b0);
    @(negedge clk);
    chk("sb_req", {31'h0, dmem_req}, 32'h1);
    chk("sb_we", {31'h0, dmem_we}, 32'h1);
    chk("sb_be", {28'h0, dmem_be}, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    chk("sb_addr", dmem_addr, 32'h1000);
    chk("sb_stall", {31'h0, stall}, 32'h0);

    // Store half to upper lanes.
    step();
    drive(1'b1, I_SH, 32'h2002, 32'h1234ABCD);
    push(1'b1, I_SH, 32'h2002, 1'b0);
    @(negedge clk);
    chk("sh_be", {28'h0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_addr", dmem_addr, 32'h2000);
    chk("sh_stall", {31'h0, stall}, 32'h0);

    do_load("lb",  I_LB,  32'h2002, 32'h00800000, 4'b0100, 32'hFFFFFF80);
    do_load("lbu", I_LBU, 32'h2002, 32'h00800000, 4'b0100, 32'h00000080);
    do_load("lh",  I_LH,  32'h2002, 32'hBEEF1234, 4'b1100, 32'hFFFFBEEF);

    // LW: grant arrives in cycle 3, data in cycle 5; a stray rvalid in cycle 1 must be ignored.
    step();
    drive(1'b1, I_LW, 32'h4000, 32'h0);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      dmem_gnt    = (c == 3);
      dmem_rvalid = (c == 1) || (c == 5);
      dmem_rdata  = (c == 5) ? 32'hCAFEF00D : 32'h11111111;
      if (c == 5) push(1'b1, I_LW, 32'hCAFEF00D, 1'b0);
      @(negedge clk);
      chk($sformatf("lw_stall_c%0d", c), {31'h0, stall}, (c < 5) ? 32'h1 : 32'h0);
      if (c <= 3) begin
        chk($sformatf("lw_req_c%0d", c), {31'h0, dmem_req}, 32'h1);
        chk($sformatf("lw_addr_c%0d", c), dmem_addr, 32'h4000);
        chk($sformatf("lw_be_c%0d", c), {28'h0, dmem_be}, 32'hF);
        chk($sformatf("lw_we_c%0d", c), {31'h0, dmem_we}, 32'h0);
      end else begin
        chk($sformatf("lw_req_c%0d", c), {31'h0, dmem_req}, 32'h0);
      end
    end

    // Reset while waiting for a response; the late response must be dropped.
    step();
    drive(1'b1, I_LW, 32'h5000, 32'h0);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
    step();
    dmem_gnt = 1'b0;
    @(negedge clk);
    chk("rsp_wait_stall", {31'h0, stall}, 32'h1);
    step();
    rst = 1'b1;
    drive(1'b0, NOP, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("mid_rst_valid", {31'h0, mem_wb_valid}, 32'h0);
    chk("mid_rst_instr", instr_mem_wb, NOP);
    chk("mid_rst_output", mem_wb_output, 32'h0);
    chk("mid_rst_stall", {31'h0, stall}, 32'h0);
    chk("mid_rst_req", {31'h0, dmem_req}, 32'h0);
    step();
    dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rsp_dropped", {31'h0, mem_wb_valid}, 32'h0);

    // Misaligned word load.
    step();
    drive(1'b1, I_LW, 32'h3002, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    push(1'b0, NOP, 32'h0, 1'b1);
    @(negedge clk);
    chk("mis_req", {31'h0, dmem_req}, 32'h0);
    chk("mis_stall", {31'h0, stall}, 32'h0);
    step();
    drive(1'b0, NOP, 32'h0, 32'h0);
`else
    dmem_gnt = 1'b1;
    @(negedge clk);
    chk("mis_addr", dmem_addr, 32'h3000);
    chk("mis_be", {28'h0, dmem_be}, 32'hF);
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h11223344;
    push(1'b1, I_LW, 32'h11223344, 1'b0);
    step();
    dmem_rvalid = 1'b0;
    drive(1'b0, NOP, 32'h0, 32'h0);
`endif
    @(negedge clk);
    chk("trap_one_cycle", {31'h0, misalign_trap}, 32'h0);

    step();
    drive(1'b0, NOP, 32'h0, 32'h0);
    repeat (3) step();
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
